// File: rtl/ising_axi_defs.sv
// Shared register map of the Ising responder, imported by the initiator and
// anything else that talks to the responder.
package ising_axi_defs;

  localparam logic [31:0] START_ADDR       = 32'h0000_0500;
  localparam logic [31:0] CTR_CUTOFF_ADDR  = 32'h0000_0600;
  localparam logic [31:0] CTR_MAX_ADDR     = 32'h0000_0700;
  localparam logic [31:0] PHASE_ADDR_BASE  = 32'h0000_0800;
  localparam logic [31:0] WEIGHT_ADDR_BASE = 32'h0000_1000;

  // Byte address of 32-bit word idx in a block starting at base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/ising_run_timer.sv
// Loadable 32-bit down-counter with a zero flag.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   load       load load_val on the next edge (takes priority over counting)
//   load_val   value to load
//   zero       count is zero; the counter holds at zero
module ising_run_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 32'd0);

endmodule

// File: rtl/ising_axi_initiator.sv
// Sequencer that programs an Ising responder over a simple strobe bus:
// START=0, counter cutoff/max, streamed weights, START=1, waits the anneal
// time, then reads back N phase bits one at a time.
// Ports:
//   clk, axi_rst                      clock, asynchronous active-high reset
//   cmd_start, cutoff_in, max_in,
//   run_cycles                        run request and its parameters
//   w_valid, w_data, w_ready          weight stream (ready/valid)
//   busy, done, err, phase_out        status and captured phase vector
//   wready, wr_addr, wdata            one-cycle write strobe to responder
//   arvalid_q, araddr_q               one-cycle read request
//   rready, rvalid, rresp, rdata      read data channel
// All outputs are registered.
module ising_axi_initiator
  import ising_axi_defs::*;
#(
  parameter int N                = 3,
  parameter int NUM_WEIGHT_WORDS = 5,
  parameter int RD_TIMEOUT       = 16
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic          cmd_start,
  input  logic [31:0]   cutoff_in,
  input  logic [31:0]   max_in,
  input  logic [31:0]   run_cycles,
  input  logic          w_valid,
  input  logic [31:0]   w_data,
  output logic          w_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [N-1:0]  phase_out,
  output logic          wready,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wdata,
  output logic          arvalid_q,
  output logic [31:0]   araddr_q,
  output logic          rready,
  input  logic          rvalid,
  input  logic          rresp,
  input  logic [31:0]   rdata
);

  localparam int WW = (NUM_WEIGHT_WORDS > 1) ? $clog2(NUM_WEIGHT_WORDS) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_HOLD, WR_CUTOFF, WR_MAX, WR_WEIGHT, WR_GO, RUN, RD_REQ, RD_WAIT, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    cutoff_q, cutoff_d, max_q, max_d, run_q, run_d;
  logic [WW-1:0]  w_idx_q, w_idx_d;
  logic [RW-1:0]  rd_idx_q, rd_idx_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [N-1:0]   phase_q, phase_d;
  logic           w_ready_q, w_ready_d, wready_q, wready_d, rready_q, rready_d;
  logic [31:0]    wr_addr_q, wr_addr_d, wdata_q, wdata_d, araddr_d;
  logic           arvalid_d;
  logic           tmr_load, tmr_zero;
  logic [31:0]    tmr_val;
  logic           unused_rdata;

  // Only bit 0 of the read data carries the phase.
  assign unused_rdata = ^rdata[31:1];

  // Shared timer: anneal wait in RUN, rvalid timeout in RD_WAIT.
  ising_run_timer u_timer (
    .clk      (clk),
    .rst      (axi_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    cutoff_d  = cutoff_q;
    max_d     = max_q;
    run_d     = run_q;
    w_idx_d   = w_idx_q;
    rd_idx_d  = rd_idx_q;
    err_d     = err_q;
    phase_d   = phase_q;
    done_d    = 1'b0;
    w_ready_d = 1'b0;
    wready_d  = 1'b0;
    wr_addr_d = 32'd0;
    wdata_d   = 32'd0;
    arvalid_d = 1'b0;
    araddr_d  = 32'd0;
    rready_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = 32'd0;

    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          cutoff_d  = cutoff_in;
          max_d     = max_in;
          run_d     = run_cycles;
          err_d     = 1'b0;
          w_idx_d   = '0;
          rd_idx_d  = '0;
          wready_d  = 1'b1;
          wr_addr_d = START_ADDR;
          state_d   = WR_HOLD;
        end
      end
      WR_HOLD: begin
        wready_d  = 1'b1;
        wr_addr_d = CTR_CUTOFF_ADDR;
        wdata_d   = cutoff_q;
        state_d   = WR_CUTOFF;
      end
      WR_CUTOFF: begin
        // Raise w_ready together with the MAX write so the first weight can
        // be written on the very next cycle.
        wready_d  = 1'b1;
        wr_addr_d = CTR_MAX_ADDR;
        wdata_d   = max_q;
        w_ready_d = 1'b1;
        state_d   = WR_MAX;
      end
      WR_MAX, WR_WEIGHT: begin
        w_ready_d = 1'b1;
        state_d   = WR_WEIGHT;
        if (w_valid && w_ready_q) begin
          wready_d  = 1'b1;
          wr_addr_d = word_addr(WEIGHT_ADDR_BASE, 32'(w_idx_q));
          wdata_d   = w_data;
          if (w_idx_q == WW'(NUM_WEIGHT_WORDS - 1)) begin
            w_ready_d = 1'b0;
            state_d   = WR_GO;
          end else begin
            w_idx_d = w_idx_q + 1'b1;
          end
        end
      end
      WR_GO: begin
        wready_d  = 1'b1;
        wr_addr_d = START_ADDR;
        wdata_d   = 32'd1;
        // The timer starts counting in the cycle the START=1 write is on the
        // bus; loading run-1 puts the first read exactly run_cycles later.
        tmr_load  = 1'b1;
        tmr_val   = (run_q == 32'd0) ? 32'd0 : run_q - 32'd1;
        state_d   = RUN;
      end
      RUN: begin
        if (tmr_zero) begin
          arvalid_d = 1'b1;
          araddr_d  = word_addr(PHASE_ADDR_BASE, 32'(rd_idx_q));
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        rready_d = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = 32'(RD_TIMEOUT - 1);
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        if (rvalid) begin
          phase_d[rd_idx_q] = rdata[0];
          if (rresp) begin
            err_d = 1'b1;
          end
          if (rd_idx_q == RW'(N - 1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rd_idx_d  = rd_idx_q + 1'b1;
            arvalid_d = 1'b1;
            araddr_d  = word_addr(PHASE_ADDR_BASE, 32'(rd_idx_q + 1'b1));
            state_d   = RD_REQ;
          end
        end else if (tmr_zero) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rready_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q   <= IDLE;
      cutoff_q  <= 32'd0;
      max_q     <= 32'd0;
      run_q     <= 32'd0;
      w_idx_q   <= '0;
      rd_idx_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      phase_q   <= '0;
      w_ready_q <= 1'b0;
      wready_q  <= 1'b0;
      wr_addr_q <= 32'd0;
      wdata_q   <= 32'd0;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cutoff_q  <= cutoff_d;
      max_q     <= max_d;
      run_q     <= run_d;
      w_idx_q   <= w_idx_d;
      rd_idx_q  <= rd_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      phase_q   <= phase_d;
      w_ready_q <= w_ready_d;
      wready_q  <= wready_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      rready_q  <= rready_d;
    end
  end

  assign w_ready   = w_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign phase_out = phase_q;
  assign wready    = wready_q;
  assign wr_addr   = wr_addr_q;
  assign wdata     = wdata_q;
  assign rready    = rready_q;

endmodule

// File: tb/tb_ising_axi_initiator.sv
// Randomized self-checking bench for ising_axi_initiator. A monitor logs every
// write/read strobe with its cycle number; each run is then compared against
// the expected transaction list and timing built from the register map.
module tb_ising_axi_initiator;

  localparam int N  = 3;
  localparam int NW = 5;
  localparam int RT = 16;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b0;
  logic          cmd_start = 1'b0;
  logic [31:0]   cutoff_in = '0, max_in = '0, run_cycles = '0;
  logic          w_valid = 1'b0;
  logic [31:0]   w_data = '0;
  logic          w_ready, busy, done, err;
  logic [N-1:0]  phase_out;
  logic          wready, arvalid_q, rready;
  logic [31:0]   wr_addr, wdata, araddr_q;
  logic          rvalid = 1'b0, rresp = 1'b0;
  logic [31:0]   rdata = '0;

  ising_axi_initiator #(.N(N), .NUM_WEIGHT_WORDS(NW), .RD_TIMEOUT(RT)) dut (
    .clk(clk), .axi_rst(axi_rst), .cmd_start(cmd_start), .cutoff_in(cutoff_in),
    .max_in(max_in), .run_cycles(run_cycles), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .busy(busy), .done(done), .err(err), .phase_out(phase_out),
    .wready(wready), .wr_addr(wr_addr), .wdata(wdata), .arvalid_q(arvalid_q),
    .araddr_q(araddr_q), .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log
  int          wq_cyc[$];
  logic [31:0] wq_addr[$], wq_data[$];
  int          rq_cyc[$];
  logic [31:0] rq_addr[$];
  int          done_cnt = 0, done_cyc = -1, err_cyc = -1, busy_cnt = 0, overlap_cnt = 0;
  logic        err_prev = 1'b0;

  always @(negedge clk) begin
    if (wready) begin
      wq_cyc.push_back(cyc); wq_addr.push_back(wr_addr); wq_data.push_back(wdata);
    end
    if (arvalid_q) begin
      rq_cyc.push_back(cyc); rq_addr.push_back(araddr_q);
    end
    if (wready && arvalid_q) overlap_cnt <= overlap_cnt + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (err && !err_prev) err_cyc <= cyc;
    err_prev <= err;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_quiet(input string t);
    chk({t, "_busy"}, 32'(busy), 0);
    chk({t, "_done"}, 32'(done), 0);
    chk({t, "_err"}, 32'(err), 0);
    chk({t, "_phase"}, 32'(phase_out), 0);
    chk({t, "_strobes"}, 32'({w_ready, wready, arvalid_q, rready}), 0);
    chk({t, "_buses"}, wr_addr | wdata | araddr_q, 0);
  endtask

  // Responder / stream configuration for the next run
  logic [31:0]  wt[NW];
  logic         resp_bit[N], resp_err[N];
  int           resp_dly[N], rv_cyc[N];
  bit           resp_tmo;
  logic [N-1:0] exp_phase = '0;

  task automatic run_one(input logic [31:0] cut, input logic [31:0] mx, input logic [31:0] rc,
                         input bit gaps, input int withhold, input bit inject);
    int c0, wb, rb, db, bb, ob, nr, s, dexp, answered;
    logic [31:0] ea[NW+4], ed[NW+4];
    logic exp_err;
    for (int k = 0; k < NW; k++) wt[k] = $urandom;
    resp_tmo = 0;
    @(negedge clk);
    wb = wq_cyc.size(); rb = rq_cyc.size(); db = done_cnt; bb = busy_cnt; ob = overlap_cnt;
    cutoff_in = cut; max_in = mx; run_cycles = rc; cmd_start = 1'b1; c0 = cyc;
    @(negedge clk);
    cmd_start = 1'b0; cutoff_in = $urandom; max_in = $urandom; run_cycles = $urandom;
    fork
      begin
        for (int k = 0; k < NW; k++) begin
          int bw = 0;
          if (gaps) repeat ($urandom_range(0, 2)) begin w_valid = 1'b0; @(negedge clk); end
          w_valid = 1'b1; w_data = wt[k];
          while (!w_ready && bw < 200) begin @(negedge clk); bw++; end
          if (!w_ready) begin resp_tmo = 1; break; end
          @(negedge clk);
        end
        w_valid = 1'b0;
      end
      begin
        for (int i = 0; i < N; i++) begin
          int ba = 0;
          logic [31:0] r;
          while (!arvalid_q && ba < 200) begin @(negedge clk); ba++; end
          if (!arvalid_q) begin resp_tmo = 1; break; end
          if (i == withhold) break;
          repeat (resp_dly[i]) @(negedge clk);
          r = $urandom; r[0] = resp_bit[i];
          rvalid = 1'b1; rresp = resp_err[i]; rdata = r; rv_cyc[i] = cyc;
          @(negedge clk);
          rvalid = 1'b0; rresp = 1'b0;
        end
      end
      begin
        if (inject) begin
          int bi = 0;
          while (wq_cyc.size() < wb + NW + 4 && bi < 200) begin @(negedge clk); bi++; end
          @(negedge clk);
          cmd_start = 1'b1; cutoff_in = 32'hDEAD_BEEF;
          @(negedge clk);
          cmd_start = 1'b0;
        end
      end
    join
    begin
      int bd = 0;
      while (done_cnt == db && bd < 200) begin @(negedge clk); bd++; end
    end
    repeat (4) @(negedge clk);

    // Expected write list from the register map
    ea[0] = 32'h500; ed[0] = 32'd0;
    ea[1] = 32'h600; ed[1] = cut;
    ea[2] = 32'h700; ed[2] = mx;
    for (int k = 0; k < NW; k++) begin ea[3+k] = 32'h1000 + 32'(4*k); ed[3+k] = wt[k]; end
    ea[NW+3] = 32'h500; ed[NW+3] = 32'd1;

    chk("stim_bound", 32'(resp_tmo), 0);
    chk("wr_count", wq_cyc.size() - wb, NW + 4);
    for (int j = 0; j < NW + 4; j++) begin
      if (wb + j < wq_cyc.size()) begin
        chk($sformatf("wr%0d_addr", j), wq_addr[wb+j], ea[j]);
        chk($sformatf("wr%0d_data", j), wq_data[wb+j], ed[j]);
      end
    end
    if (wq_cyc.size() >= wb + NW + 4) begin
      s = wq_cyc[wb+NW+3];
      chk("wr_first_cyc", wq_cyc[wb], c0 + 1);
      if (!gaps) chk("wr_back2back", s - wq_cyc[wb], NW + 3);
    end else s = 0;

    answered = (withhold < 0) ? N : withhold;
    nr = (withhold < 0) ? N : withhold + 1;
    chk("rd_count", rq_cyc.size() - rb, nr);
    for (int i = 0; i < nr; i++) begin
      if (rb + i < rq_cyc.size()) begin
        chk($sformatf("rd%0d_addr", i), rq_addr[rb+i], 32'h800 + 32'(4*i));
        if (i > 0) chk($sformatf("rd%0d_cyc", i), rq_cyc[rb+i], rv_cyc[i-1] + 1);
      end
    end
    if (rb < rq_cyc.size()) chk("run_wait", rq_cyc[rb] - s, (rc == 0) ? 1 : rc);

    exp_err = 1'b0;
    for (int i = 0; i < answered; i++) begin
      exp_phase[i] = resp_bit[i];
      exp_err = exp_err | resp_err[i];
    end
    if (withhold >= 0) exp_err = 1'b1;
    if (withhold < 0) dexp = rv_cyc[N-1] + 1;
    else if (rb + withhold < rq_cyc.size()) dexp = rq_cyc[rb+withhold] + RT + 1;
    else dexp = -2;

    chk("done_pulses", done_cnt - db, 1);
    chk("done_cyc", done_cyc, dexp);
    if (withhold >= 0) chk("err_timeout_cyc", err_cyc, dexp);
    chk("phase_out", 32'(phase_out), 32'(exp_phase));
    chk("err", 32'(err), 32'(exp_err));
    chk("busy_after", 32'(busy), 0);
    chk("busy_cycles", busy_cnt - bb, dexp - c0);
    chk("wr_rd_overlap", overlap_cnt - ob, 0);
  endtask

  task automatic set_resp(input logic [N-1:0] bits, input logic [N-1:0] errs, input bit rnd_dly);
    for (int i = 0; i < N; i++) begin
      resp_bit[i] = bits[i];
      resp_err[i] = errs[i];
      resp_dly[i] = rnd_dly ? int'($urandom_range(1, 4)) : 1;
    end
  endtask

  initial begin
    #2 axi_rst = 1'b1;
    #1 check_quiet("reset");
    repeat (2) @(negedge clk);
    axi_rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // Back-to-back weights, responder bits 1,0,1, 10-cycle anneal
    set_resp(3'b101, 3'b000, 1'b0);
    run_one($urandom, $urandom, 32'd10, 1'b0, -1, 1'b0);
    chk("phase_101", 32'(phase_out), 32'h5);

    // Zero anneal time
    set_resp(3'b010, 3'b000, 1'b1);
    run_one($urandom, $urandom, 32'd0, 1'b0, -1, 1'b0);

    // Read 1 never answered: timeout, read 2 skipped, bit 1/2 kept
    set_resp(3'b110, 3'b000, 1'b0);
    run_one($urandom, $urandom, 32'd3, 1'b0, 1, 1'b0);

    // Error response still stores the bit
    set_resp(3'b111, 3'b010, 1'b1);
    run_one($urandom, $urandom, 32'd1, 1'b1, -1, 1'b0);

    // Reset in the middle of the weight stream
    begin
      int wb;
      @(negedge clk);
      cutoff_in = $urandom; max_in = $urandom; run_cycles = 32'd5; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; w_valid = 1'b1; w_data = $urandom;
      repeat (4) @(negedge clk);
      chk("pre_reset_busy", 32'(busy), 1);
      chk("pre_reset_wready_stream", 32'(w_ready), 1);
      #2 wb = wq_cyc.size();
      axi_rst = 1'b1;
      #1 check_quiet("midrun_reset");
      exp_phase = '0;
      @(negedge clk); @(negedge clk);
      axi_rst = 1'b0; w_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("no_strobe_after_reset", wq_cyc.size() - wb, 0);
    end
    set_resp(3'b011, 3'b000, 1'b1);
    run_one($urandom, $urandom, 32'd4, 1'b0, -1, 1'b0);

    // cmd_start while in RUN is ignored
    set_resp(3'b100, 3'b000, 1'b1);
    run_one($urandom, $urandom, 32'd12, 1'b0, -1, 1'b1);

    // Random runs
    for (int r = 0; r < 6; r++) begin
      logic [N-1:0] b, e;
      b = N'($urandom);
      e = N'($urandom & $urandom);
      set_resp(b, e, 1'b1);
      run_one($urandom, $urandom, 32'($urandom_range(0, 20)), 1'($urandom), -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/ising_axi_initiator.md
ISING_AXI_INITIATOR -- requirements
Module: ising_axi_initiator

Interface
REQ-001 SHALL have parameter N, default 3, spin count and number of phase bits read back.
REQ-002 SHALL have parameter NUM_WEIGHT_WORDS, default 5, number of 32-bit weight words written per run.
REQ-003 SHALL have parameter RD_TIMEOUT, default 16, maximum cycles to wait for rvalid.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports:
- clk  in  1  single clock
- axi_rst  in  1  asynchronous active-high reset
- cmd_start  in  1  run request, one-cycle pulse
- cutoff_in  in  32  counter cutoff value
- max_in  in  32  counter max value
- run_cycles  in  32  anneal wait, in clk cycles
- w_valid  in  1  weight stream valid
- w_data  in  32  weight stream word
- w_ready  out  1  weight stream ready
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag
- phase_out  out  N  captured phase vector
- wready  out  1  write strobe to responder
- wr_addr  out  32  write address
- wdata  out  32  write data
- arvalid_q  out  1  read request pulse
- araddr_q  out  32  read address
- rready  out  1  read data accept
- rvalid  in  1  read data valid
- rresp  in  1  read response, 1 = error
- rdata  in  32  read data; bit 0 is the phase bit

Function
REQ-006 SHALL use states IDLE, WR_HOLD, WR_CUTOFF, WR_MAX, WR_WEIGHT, WR_GO, RUN, RD_REQ, RD_WAIT, DONE.
REQ-007 IDLE: cmd_start SHALL latch cutoff_in, max_in and run_cycles, clear err, and move to WR_HOLD; cmd_start while busy SHALL be ignored.
REQ-008 Writes SHALL be single-cycle registered pulses: wready=1 with wr_addr/wdata for exactly one cycle, with no back-pressure.
REQ-009 Write order SHALL be:
- START_ADDR, wdata 0
- CTR_CUTOFF_ADDR, cutoff
- CTR_MAX_ADDR, max
- weight k at WEIGHT_ADDR_BASE+4k, k=0..NUM_WEIGHT_WORDS-1
- START_ADDR, wdata 1
REQ-010 WR_WEIGHT SHALL assert w_ready; each w_valid&w_ready handshake SHALL produce the weight write on the next cycle; a w_valid gap SHALL stall without timeout.
REQ-011 RUN SHALL wait exactly run_cycles cycles after the START=1 write; run_cycles=0 SHALL go directly to RD_REQ.
REQ-012 RD_REQ SHALL pulse arvalid_q for one cycle with araddr_q=PHASE_ADDR_BASE+4i, i=0..N-1 ascending.
REQ-013 RD_WAIT SHALL hold rready=1; rvalid SHALL load rdata[0] into phase_out[i] in the same edge, and the next read SHALL be issued the following cycle.
REQ-014 rvalid with rresp=1 SHALL set err and still store the bit.
REQ-015 No rvalid within RD_TIMEOUT cycles SHALL set err, abort the remaining reads and go to DONE.
REQ-016 DONE SHALL pulse done for one cycle and return to IDLE; the Ising core SHALL be left running.
REQ-017 busy SHALL be 1 in every state except IDLE; phase_out SHALL hold its value until the next run reaches RD_WAIT.
REQ-018 wready and arvalid_q SHALL never be asserted in the same cycle.

Reset
REQ-019 axi_rst SHALL asynchronously force IDLE with every output 0, including phase_out and err, and all latched values 0.
REQ-020 Reset mid-sequence SHALL abandon the transaction; no write or read strobe SHALL appear in the reset cycle or after it.

Structure
REQ-021 START/CTR_CUTOFF/CTR_MAX/PHASE/WEIGHT address constants (0x500, 0x600, 0x700, 0x800, 0x1000) SHALL come from the shared ising_axi_defs header used by the responder; state encodings SHALL stay local.
REQ-022 The RUN wait and read timeout SHALL use one sub-module, ising_run_timer (loadable 32-bit down-counter with zero flag).

Verification
REQ-023 N=3, NUM_WEIGHT_WORDS=5, weights streamed back-to-back SHALL produce writes 0x500/0, 0x600, 0x700, 0x1000..0x1010, 0x500/1 on 9 consecutive cycles.
REQ-024 A responder model returning bits 1,0,1 SHALL give phase_out=3'b101, a done pulse and err=0.
REQ-025 run_cycles=10 SHALL put the first arvalid_q exactly 10 cycles after the START=1 write; run_cycles=0 SHALL issue it on the next cycle.
REQ-026 A responder that withholds rvalid for read 1 SHALL set err after 16 cycles, skip read 2 and pulse done.
REQ-027 axi_rst asserted during WR_WEIGHT, then cmd_start, SHALL restart with the START=0 write and weight index 0.
REQ-028 cmd_start pulsed during RUN SHALL have no effect on the address sequence.
